// File: rtl/spw_link_ctrl_fsm.sv
// SpaceWire link-initialisation FSM with parametrised timeouts, latched error cause and bounded auto-start retries.
// Optional macro SPW_LINK_STATS_EN enables the 16-bit RUN-exit error counter on link_err_cnt.
module spw_link_ctrl_fsm #(
    parameter int CNT_W       = 12,
    parameter int T_RESET_CYC = 640,
    parameter int T_WAIT_CYC  = 1280,
    parameter int T_DISC_CYC  = 86,
    parameter int MAX_RETRY   = 4
) (
    input  logic        pclk,
    input  logic        resetn,
    input  logic        auto_start,
    input  logic        link_start,
    input  logic        link_disable,
    input  logic        err_cause_clr,
    input  logic        rx_error,
    input  logic        rx_credit_error,
    input  logic        rx_got_bit,
    input  logic        rx_got_null,
    input  logic        rx_got_fct,
    input  logic        rx_got_nchar,
    input  logic        rx_got_time_code,
    output logic        rx_resetn,
    output logic        enable_tx,
    output logic        send_null_tx,
    output logic        send_fct_tx,
    output logic [2:0]  fsm_state,
    output logic [2:0]  err_cause,
    output logic        retry_exhausted,
    output logic [15:0] link_err_cnt
);

    typedef enum logic [2:0] {
        S_ERROR_RESET = 3'd0,
        S_ERROR_WAIT  = 3'd1,
        S_READY       = 3'd2,
        S_STARTED     = 3'd3,
        S_CONNECTING  = 3'd4,
        S_RUN         = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE       = 3'd0,
        C_RX_ERROR   = 3'd1,
        C_CREDIT     = 3'd2,
        C_DISCONNECT = 3'd3,
        C_DISABLE    = 3'd4,
        C_TIMEOUT    = 3'd5,
        C_UNEXPECTED = 3'd6
    } cause_t;

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(T_RESET_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(T_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] DISC_LAST  = CNT_W'(T_DISC_CYC - 1);
    localparam logic [CNT_W-1:0] TIMER_SAT  = '1;
    localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRY);

    state_t           state, next_state;
    cause_t           cause, err_q;
    logic [CNT_W-1:0] timer, next_timer;
    logic [RW-1:0]    retry_cnt;
    logic             err_set, unexp_all, unexp_conn;
    logic             reset_exp, wait_exp, disc_exp;
    logic             enter_err, enter_run, retry_fail;

    assign err_set    = rx_error | rx_got_fct | rx_got_nchar | rx_got_time_code;
    assign unexp_all  = rx_got_fct | rx_got_nchar | rx_got_time_code;
    assign unexp_conn = rx_got_nchar | rx_got_time_code;
    assign reset_exp  = (timer == RESET_LAST);
    assign wait_exp   = (timer == WAIT_LAST);
    assign disc_exp   = (timer == DISC_LAST);

    // Next state and the cause that goes with any transition into ERROR_RESET.
    always_comb begin
        next_state = state;
        cause      = C_NONE;
        case (state)
            S_ERROR_RESET: begin
                if (reset_exp) next_state = S_ERROR_WAIT;
            end
            S_ERROR_WAIT: begin
                if (err_set) begin
                    next_state = S_ERROR_RESET;
                    cause      = rx_error ? C_RX_ERROR : C_UNEXPECTED;
                end else if (wait_exp) begin
                    next_state = S_READY;
                end
            end
            S_READY: begin
                if (err_set) begin
                    next_state = S_ERROR_RESET;
                    cause      = rx_error ? C_RX_ERROR : C_UNEXPECTED;
                end else if (!link_disable &&
                             (link_start || (auto_start && rx_got_null && !retry_exhausted))) begin
                    next_state = S_STARTED;
                end
            end
            S_STARTED: begin
                if (err_set || wait_exp) begin
                    next_state = S_ERROR_RESET;
                    if (rx_error)      cause = C_RX_ERROR;
                    else if (wait_exp) cause = C_TIMEOUT;
                    else if (unexp_all) cause = C_UNEXPECTED;
                end else if (rx_got_null) begin
                    next_state = S_CONNECTING;
                end
            end
            S_CONNECTING: begin
                if (rx_error || unexp_conn || wait_exp) begin
                    next_state = S_ERROR_RESET;
                    if (rx_error)      cause = C_RX_ERROR;
                    else if (wait_exp) cause = C_TIMEOUT;
                    else               cause = C_UNEXPECTED;
                end else if (rx_got_fct) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (rx_error || rx_credit_error || link_disable || disc_exp) begin
                    next_state = S_ERROR_RESET;
                    if (rx_error)             cause = C_RX_ERROR;
                    else if (rx_credit_error) cause = C_CREDIT;
                    else if (disc_exp)        cause = C_DISCONNECT;
                    else                      cause = C_DISABLE;
                end
            end
            default: next_state = S_ERROR_RESET;
        endcase
    end

    // In RUN the timer measures bit inactivity; READY never counts.
    always_comb begin
        next_timer = timer;
        if (next_state != state) begin
            next_timer = '0;
        end else if (state == S_RUN && rx_got_bit) begin
            next_timer = '0;
        end else if (state != S_READY && timer != TIMER_SAT) begin
            next_timer = timer + CNT_W'(1);
        end
    end

    assign enter_err  = (state != S_ERROR_RESET) && (next_state == S_ERROR_RESET);
    assign enter_run  = (state != S_RUN) && (next_state == S_RUN);
    assign retry_fail = enter_err && (state == S_STARTED || state == S_CONNECTING);

    always_ff @(posedge pclk) begin
        if (!resetn) begin
            state        <= S_ERROR_RESET;
            timer        <= '0;
            rx_resetn    <= 1'b0;
            enable_tx    <= 1'b0;
            send_null_tx <= 1'b0;
            send_fct_tx  <= 1'b0;
        end else begin
            state        <= next_state;
            timer        <= next_timer;
            rx_resetn    <= (next_state != S_ERROR_RESET);
            enable_tx    <= next_state inside {S_READY, S_STARTED, S_CONNECTING, S_RUN};
            send_null_tx <= next_state inside {S_STARTED, S_CONNECTING, S_RUN};
            send_fct_tx  <= next_state inside {S_CONNECTING, S_RUN};
        end
    end

    // A fresh error load takes precedence over a same-cycle clear.
    always_ff @(posedge pclk) begin
        if (!resetn) begin
            err_q <= C_NONE;
        end else if (enter_err) begin
            err_q <= cause;
        end else if (err_cause_clr) begin
            err_q <= C_NONE;
        end
    end

    always_ff @(posedge pclk) begin
        if (!resetn) begin
            retry_cnt <= '0;
        end else if (link_start || enter_run) begin
            retry_cnt <= '0;
        end else if (retry_fail && MAX_RETRY != 0 && retry_cnt != RETRY_MAX) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end

    assign retry_exhausted = (MAX_RETRY != 0) && (retry_cnt == RETRY_MAX);
    assign fsm_state       = state;
    assign err_cause       = err_q;

`ifdef SPW_LINK_STATS_EN
    logic [15:0] stat_cnt;
    logic        run_fail;

    assign run_fail = enter_err && (state == S_RUN);

    always_ff @(posedge pclk) begin
        if (!resetn) begin
            stat_cnt <= '0;
        end else if (run_fail) begin
            if (stat_cnt != 16'hFFFF) stat_cnt <= stat_cnt + 16'd1;
        end else if (err_cause_clr) begin
            stat_cnt <= '0;
        end
    end

    assign link_err_cnt = stat_cnt;
`else
    assign link_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_spw_link_ctrl_fsm.sv
// Scoreboard bench for spw_link_ctrl_fsm: expected output snapshots (with dwell of the previous one) are queued by the driver and checked on every output change.
module tb_spw_link_ctrl_fsm;

    localparam int W  = 43;
    localparam int DC = 65535;

    logic        pclk = 1'b0;
    logic        resetn = 1'b0;
    logic        auto_start = 1'b0, link_start = 1'b0, link_disable = 1'b0, err_cause_clr = 1'b0;
    logic        rx_error = 1'b0, rx_credit_error = 1'b0, rx_got_bit = 1'b0, rx_got_null = 1'b0;
    logic        rx_got_fct = 1'b0, rx_got_nchar = 1'b0, rx_got_time_code = 1'b0;
    logic        rx_resetn, enable_tx, send_null_tx, send_fct_tx, retry_exhausted;
    logic [2:0]  fsm_state, err_cause;
    logic [15:0] link_err_cnt;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           armed = 1'b0;
    logic [26:0]  prev_snap;
    int           last_cyc;

    spw_link_ctrl_fsm dut (
        .pclk(pclk), .resetn(resetn), .auto_start(auto_start), .link_start(link_start),
        .link_disable(link_disable), .err_cause_clr(err_cause_clr), .rx_error(rx_error),
        .rx_credit_error(rx_credit_error), .rx_got_bit(rx_got_bit), .rx_got_null(rx_got_null),
        .rx_got_fct(rx_got_fct), .rx_got_nchar(rx_got_nchar), .rx_got_time_code(rx_got_time_code),
        .rx_resetn(rx_resetn), .enable_tx(enable_tx), .send_null_tx(send_null_tx),
        .send_fct_tx(send_fct_tx), .fsm_state(fsm_state), .err_cause(err_cause),
        .retry_exhausted(retry_exhausted), .link_err_cnt(link_err_cnt)
    );

    // Clock / cycle counter
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic logic [15:0] stat(input int n);
`ifdef SPW_LINK_STATS_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [26:0] snap();
        return {fsm_state, rx_resetn, enable_tx, send_null_tx, send_fct_tx,
                err_cause, retry_exhausted, link_err_cnt};
    endfunction

    // Expected snapshot: dwell of the previous snapshot, state, derived strobes, cause, exhausted, stats.
    task automatic push(input int dwell, input int st, input int ec, input bit rx, input int cnt);
        logic [15:0] d16;
        logic [2:0]  s3;
        logic [2:0]  e3;
        d16 = 16'(dwell);
        s3  = 3'(st);
        e3  = 3'(ec);
        exp_q.push_back({d16, s3, (st != 0), (st >= 2), (st >= 3), (st >= 4), e3, rx, stat(cnt)});
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_state(input int st, input int budget);
        int n;
        n = 0;
        while (fsm_state != 3'(st) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (fsm_state != 3'(st)) begin
            errors++;
            $display("FAIL wait_state_%0d timeout: state=%0d required=%0d", st, fsm_state, st);
        end
    endtask

    task automatic bring_up(input int rd, input int ec, input int cnt);
        push(rd, 3, ec, 1'b0, cnt);
        push(3, 4, ec, 1'b0, cnt);
        push(1, 5, ec, 1'b0, cnt);
        link_start = 1'b1;
        tick();
        link_start = 1'b0;
        tick();
        tick();
        rx_got_null = 1'b1;
        tick();
        rx_got_null = 1'b0;
        rx_got_fct = 1'b1;
        tick();
        rx_got_fct = 1'b0;
    endtask

    // Monitor: every output change pops and checks one expected snapshot.
    always @(negedge pclk) begin
        logic [26:0]  cur;
        logic [W-1:0] e;
        int           dwell;
        if (armed) begin
            cur = snap();
            if (cur != prev_snap) begin
                dwell = cyc - last_cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h after %0d cycles, required no change", cur, dwell);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e[26:0] || (e[42:27] != 16'hFFFF && dwell != int'(e[42:27]))) begin
                        errors++;
                        $display("FAIL snapshot: got %h dwell %0d, required %h dwell %0d",
                                 cur, dwell, e[26:0], e[42:27]);
                    end
                end
                prev_snap = cur;
                last_cyc  = cyc;
            end
        end
    end

    initial begin
        int n;
        repeat (4) tick();
        checks++;
        if (snap() != 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", snap());
        end

        // Power-up: ERROR_RESET 640, ERROR_WAIT 1280, then READY.
        push(640, 1, 0, 1'b0, 0);
        push(1280, 2, 0, 1'b0, 0);
        resetn    = 1'b1;
        prev_snap = snap();
        last_cyc  = cyc;
        armed     = 1'b1;
        wait_state(2, 2500);

        // Manual start then silent RUN: disconnect after 86 cycles.
        bring_up(1, 0, 0);
        push(86, 0, 3, 1'b0, 1);
        push(640, 1, 3, 1'b0, 1);
        push(1280, 2, 3, 1'b0, 1);
        wait_state(0, 200);
        wait_state(2, 2500);

        // Bit activity every 80 cycles keeps RUN; then rx_error+credit, then clear.
        bring_up(1, 3, 1);
        for (int i = 0; i < 5; i++) begin
            repeat (79) tick();
            rx_got_bit = 1'b1;
            tick();
            rx_got_bit = 1'b0;
        end
        push(DC, 0, 1, 1'b0, 2);
        push(1, 0, 0, 1'b0, 0);
        push(639, 1, 0, 1'b0, 0);
        push(1280, 2, 0, 1'b0, 0);
        rx_error = 1'b1;
        rx_credit_error = 1'b1;
        tick();
        rx_error = 1'b0;
        rx_credit_error = 1'b0;
        err_cause_clr = 1'b1;
        tick();
        err_cause_clr = 1'b0;
        wait_state(2, 2500);

        // Three link_disable drops from RUN.
        for (int k = 1; k <= 3; k++) begin
            bring_up(1, (k == 1) ? 0 : 4, k - 1);
            push(3, 0, 4, 1'b0, k);
            push(640, 1, 4, 1'b0, k);
            push(1280, 2, 4, 1'b0, k);
            tick();
            tick();
            link_disable = 1'b1;
            tick();
            link_disable = 1'b0;
            wait_state(2, 2500);
        end

        // Auto-start with NULLs but no FCT: four CONNECTING timeouts, then inhibited.
        push(1, 3, 4, 1'b0, 3);
        push(1, 4, 4, 1'b0, 3);
        for (int i = 1; i <= 4; i++) begin
            push(1280, 0, 5, (i == 4), 3);
            push(640, 1, 5, (i == 4), 3);
            push(1280, 2, 5, (i == 4), 3);
            if (i < 4) begin
                push(1, 3, 5, 1'b0, 3);
                push(1, 4, 5, 1'b0, 3);
            end
        end
        auto_start  = 1'b1;
        rx_got_null = 1'b1;
        n = 0;
        while (!(fsm_state == 3'd2 && retry_exhausted) && n < 16000) begin
            tick();
            n++;
        end
        checks++;
        if (!(fsm_state == 3'd2 && retry_exhausted)) begin
            errors++;
            $display("FAIL retry_exhaust_wait: state=%0d exhausted=%0d, required 2/1", fsm_state, retry_exhausted);
        end
        repeat (200) tick();

        // link_start overrides the inhibit; then an N-char in CONNECTING.
        push(201, 3, 5, 1'b0, 3);
        push(1, 4, 5, 1'b0, 3);
        push(1, 0, 6, 1'b0, 3);
        push(640, 1, 6, 1'b0, 3);
        push(1280, 2, 6, 1'b0, 3);
        link_start = 1'b1;
        tick();
        link_start = 1'b0;
        tick();
        rx_got_null  = 1'b0;
        auto_start   = 1'b0;
        rx_got_nchar = 1'b1;
        tick();
        rx_got_nchar = 1'b0;
        wait_state(2, 2500);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d snapshots outstanding, required 0", exp_q.size());
        end
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
